// File: rtl/stream_demux_1x4_buf.sv
// Buffered 1-to-4 stream router: each word is steered by in_sel into one of
// four per-channel FIFOs, each drained independently over valid/ready.
module stream_demux_1x4_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic [DATA_W-1:0]   in_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [4*CNT_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [3:0] full;

  // Stall depends only on the target channel, never on in_valid.
  assign in_ready = ~full[in_sel];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push;
    logic              pop;

    assign push = in_valid && in_ready && (in_sel == 2'(k));
    assign pop  = (cnt != '0) && out_ready[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        mem    <= '{default: '0};
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign full[k]                       = (cnt == CNT_W'(DEPTH));
    assign out_valid[k]                  = (cnt != '0);
    assign out_data[k*DATA_W +: DATA_W]  = mem[rd_ptr];
    assign level[k*CNT_W +: CNT_W]       = cnt;
  end

endmodule

// File: tb/tb_stream_demux_1x4_buf.sv
// Directed self-checking bench for stream_demux_1x4_buf (DATA_W=8, DEPTH=4).
module tb_stream_demux_1x4_buf;

  localparam int DW = 8;
  localparam int CW = 3;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_sel;
  logic [DW-1:0]   in_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [4*DW-1:0] out_data;
  logic [4*CW-1:0] level;

  int unsigned total = 0;
  int unsigned bad   = 0;

  stream_demux_1x4_buf #(.DATA_W(DW), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int k);
    return out_data[k*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] lvl(input int k);
    return level[k*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;
    #12;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Route one word to each channel
    push(2'd0, 8'hA0);
    push(2'd1, 8'hA1);
    push(2'd2, 8'hA2);
    push(2'd3, 8'hA3);
    check("route_valid", 32'(out_valid), 32'hF);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("route_data%0d", k), 32'(dat(k)), 32'hA0 + 32'(k));
      check($sformatf("route_lvl%0d", k), 32'(lvl(k)), 32'h1);
    end
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    check("drain_all_valid", 32'(out_valid), 32'h0);
    check("drain_all_level", 32'(level), 32'h0);

    // Fill ch2 and probe the stall
    for (int i = 0; i < 4; i++) push(2'd2, 8'(8'h10 + i));
    check("full_lvl2", 32'(lvl(2)), 32'h4);
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 8'h14;
    #1;
    check("full_ready_ch2", 32'(in_ready), 32'h0);
    in_sel = 2'd0;
    #1;
    check("full_ready_ch0", 32'(in_ready), 32'h1);
    in_sel    = 2'd2;
    out_ready = 4'b0100;
    #1;
    check("full_pop_ready", 32'(in_ready), 32'h0);
    tick();
    in_valid = 1'b0;
    check("full_pop_lvl", 32'(lvl(2)), 32'h3);
    check("full_pop_head", 32'(dat(2)), 32'h11);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_drain_head%0d", i), 32'(dat(2)), 32'h11 + 32'(i));
      tick();
    end
    out_ready = 4'b0000;
    check("full_drain_lvl", 32'(lvl(2)), 32'h0);

    // Order and pointer wrap on ch3 with continuous pop
    out_ready = 4'b1000;
    in_sel    = 2'd3;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      check($sformatf("wrap_valid%0d", i), 32'(out_valid[3]), 32'h1);
      check($sformatf("wrap_data%0d", i), 32'(dat(3)), 32'(i));
      check($sformatf("wrap_lvl%0d", i), 32'(lvl(3)), 32'h1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    check("wrap_end_lvl", 32'(lvl(3)), 32'h0);

    // Simultaneous push and pop on ch0
    push(2'd0, 8'hB0);
    push(2'd0, 8'hB1);
    check("sim_lvl_before", 32'(lvl(0)), 32'h2);
    check("sim_head_before", 32'(dat(0)), 32'hB0);
    out_ready = 4'b0001;
    push(2'd0, 8'hB2);
    out_ready = 4'b0000;
    check("sim_lvl_after", 32'(lvl(0)), 32'h2);
    check("sim_head_after", 32'(dat(0)), 32'hB1);

    // Push into empty ch1 while its consumer is ready
    out_ready = 4'b0010;
    check("empty_valid_before", 32'(out_valid[1]), 32'h0);
    push(2'd1, 8'h55);
    check("empty_valid", 32'(out_valid[1]), 32'h1);
    check("empty_data", 32'(dat(1)), 32'h55);
    check("empty_lvl", 32'(lvl(1)), 32'h1);
    tick();
    out_ready = 4'b0000;
    check("empty_popped_valid", 32'(out_valid[1]), 32'h0);
    check("empty_popped_lvl", 32'(lvl(1)), 32'h0);

    // Reset mid-stream with ch1 holding three words
    for (int i = 0; i < 3; i++) push(2'd1, 8'(8'hC0 + i));
    check("mid_lvl1", 32'(lvl(1)), 32'h3);
    in_sel = 2'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_level", 32'(level), 32'h0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    out_ready = 4'b1111;
    tick();
    tick();
    check("post_rst_valid", 32'(out_valid), 32'h0);
    check("post_rst_level", 32'(level), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
